// File: rtl/ring_monitor.sv
// Observes a rotating one-hot ring counter: decodes position/direction, counts net laps, flags illegal codes.
// Optional RING_MON_ERRCNT_EN adds a saturating illegal-sample counter output err_cnt.
module ring_monitor #(
  parameter int W  = 4,
  parameter int CW = 8,
  localparam int PW = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  ring_in,
  input  logic          clr,
  output logic [PW-1:0] pos,
  output logic          valid,
  output logic          dir,
  output logic          step,
  output logic          jump,
  output logic          wrap,
  output logic [CW-1:0] lap,
  output logic          err
`ifdef RING_MON_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  last_q, last_d;
  logic [PW-1:0] pos_d, cur_pos;
  logic          dir_d, step_d, jump_d, wrap_d, err_d;
  logic [CW-1:0] lap_d;
  logic          is_inv, is_hold, is_left, is_right;

  assign is_inv   = !$onehot(ring_in);
  assign is_hold  = (ring_in == last_q);
  assign is_left  = (ring_in == {last_q[W-2:0], last_q[W-1]});
  assign is_right = (ring_in == {last_q[0], last_q[W-1:1]});
  assign valid    = (state_q == TRACK);

  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < W; i++)
      if (ring_in[i]) cur_pos = PW'(i);
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pos_d   = pos;
    dir_d   = dir;
    lap_d   = lap;
    step_d  = 1'b0;
    jump_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = err;
    // An illegal sample overrides a simultaneous clear.
    if (clr)    err_d = 1'b0;
    if (is_inv) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (is_inv) begin
          state_d = FAULT;
        end else begin
          state_d = TRACK;
          last_d  = ring_in;
          pos_d   = cur_pos;
        end
      end
      TRACK: begin
        if (is_inv) begin
          state_d = FAULT;
        end else if (is_hold) begin
          state_d = TRACK;
        end else if (is_left) begin
          step_d = 1'b1;
          dir_d  = 1'b1;
          last_d = ring_in;
          pos_d  = cur_pos;
          if (last_q[W-1]) begin
            wrap_d = 1'b1;
            lap_d  = lap + CW'(1);
          end
        end else if (is_right) begin
          step_d = 1'b1;
          dir_d  = 1'b0;
          last_d = ring_in;
          pos_d  = cur_pos;
          if (last_q[0]) begin
            wrap_d = 1'b1;
            lap_d  = lap - CW'(1);
          end
        end else begin
          jump_d = 1'b1;
          last_d = ring_in;
          pos_d  = cur_pos;
        end
      end
      FAULT: begin
        if (clr && !is_inv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= '0;
      pos     <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      jump    <= 1'b0;
      wrap    <= 1'b0;
      lap     <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pos     <= pos_d;
      dir     <= dir_d;
      step    <= step_d;
      jump    <= jump_d;
      wrap    <= wrap_d;
      lap     <= lap_d;
      err     <= err_d;
    end
  end

`ifdef RING_MON_ERRCNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= is_inv ? 8'd1 : 8'd0;
    end else if (is_inv && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ring_monitor.sv
// Directed-vector bench for ring_monitor (W=4, CW=8); define RING_MON_ERRCNT_EN to also exercise err_cnt.
module tb_ring_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ring_in = 4'b0001;
  logic       clr = 1'b0;
  logic [1:0] pos;
  logic       valid, dir, step, jump, wrap, err;
  logic [7:0] lap;
`ifdef RING_MON_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ring_monitor #(.W(4), .CW(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .ring_in (ring_in),
    .clr     (clr),
    .pos     (pos),
    .valid   (valid),
    .dir     (dir),
    .step    (step),
    .jump    (jump),
    .wrap    (wrap),
    .lap     (lap),
    .err     (err)
`ifdef RING_MON_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  // Observed word: {valid, pos, dir, step, jump, wrap, err, lap}
  logic [15:0] obs;
  assign obs = {valid, pos, dir, step, jump, wrap, err, lap};

  typedef struct packed {
    logic [3:0]  ring;
    logic        clr;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic c, input logic v,
                              input logic [1:0] p, input logic d, input logic s,
                              input logic j, input logic w, input logic e,
                              input logic [7:0] l);
    return {r, c, v, p, d, s, j, w, e, l};
  endfunction

  // Inputs change one time unit after the edge; outputs are sampled at the same point.
  task automatic drive(input logic [3:0] r, input logic c);
    ring_in = r;
    clr     = c;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    vectors++;
    if (obs !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs, 16'h0000);
    end
    reset = 1'b0;
    drive(4'b0001, 1'b0);
    vectors++;
    if (obs !== {1'b1, 2'd0, 5'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL first_sample: got %h expected %h", obs, {1'b1, 2'd0, 5'b0, 8'd0});
    end
  endtask

  task automatic test_rotate_left();
    vec_t q[$];
    q.push_back(mk(4'b0010, 0, 1, 2'd1, 1, 1, 0, 0, 0, 8'd0));
    q.push_back(mk(4'b0100, 0, 1, 2'd2, 1, 1, 0, 0, 0, 8'd0));
    q.push_back(mk(4'b1000, 0, 1, 2'd3, 1, 1, 0, 0, 0, 8'd0));
    q.push_back(mk(4'b0001, 0, 1, 2'd0, 1, 1, 0, 1, 0, 8'd1));
    q.push_back(mk(4'b0001, 0, 1, 2'd0, 1, 0, 0, 0, 0, 8'd1));
    foreach (q[i]) begin
      drive(q[i].ring, q[i].clr);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL left[%0d]: got %h expected %h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_rotate_right();
    vec_t q[$];
    q.push_back(mk(4'b1000, 0, 1, 2'd3, 0, 1, 0, 1, 0, 8'd0));
    q.push_back(mk(4'b0100, 0, 1, 2'd2, 0, 1, 0, 0, 0, 8'd0));
    q.push_back(mk(4'b0010, 0, 1, 2'd1, 0, 1, 0, 0, 0, 8'd0));
    q.push_back(mk(4'b0001, 0, 1, 2'd0, 0, 1, 0, 0, 0, 8'd0));
    for (int k = 1; k <= 8; k++) begin
      q.push_back(mk(4'b1000, 0, 1, 2'd3, 0, 1, 0, 1, 0, 8'(-k)));
      q.push_back(mk(4'b0100, 0, 1, 2'd2, 0, 1, 0, 0, 0, 8'(-k)));
      q.push_back(mk(4'b0010, 0, 1, 2'd1, 0, 1, 0, 0, 0, 8'(-k)));
      q.push_back(mk(4'b0001, 0, 1, 2'd0, 0, 1, 0, 0, 0, 8'(-k)));
    end
    foreach (q[i]) begin
      drive(q[i].ring, q[i].clr);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL right[%0d]: got %h expected %h", i, obs, q[i].exp);
      end
    end
    vectors++;
    if (lap !== 8'hF8) begin
      miscompares++;
      $display("FAIL lap_underflow: got %h expected %h", lap, 8'hF8);
    end
  endtask

  task automatic test_jump();
    vec_t q[$];
    q.push_back(mk(4'b0010, 0, 1, 2'd1, 1, 1, 0, 0, 0, 8'hF8));
    q.push_back(mk(4'b1000, 0, 1, 2'd3, 1, 0, 1, 0, 0, 8'hF8));
    q.push_back(mk(4'b1000, 0, 1, 2'd3, 1, 0, 0, 0, 0, 8'hF8));
    q.push_back(mk(4'b0001, 0, 1, 2'd0, 1, 1, 0, 1, 0, 8'hF9));
    foreach (q[i]) begin
      drive(q[i].ring, q[i].clr);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL jump[%0d]: got %h expected %h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_fault();
    vec_t q[$];
    q.push_back(mk(4'b0110, 0, 0, 2'd0, 1, 0, 0, 0, 1, 8'hF9));
    q.push_back(mk(4'b0110, 1, 0, 2'd0, 1, 0, 0, 0, 1, 8'hF9));
    q.push_back(mk(4'b0010, 0, 0, 2'd0, 1, 0, 0, 0, 1, 8'hF9));
    q.push_back(mk(4'b0010, 1, 0, 2'd0, 1, 0, 0, 0, 0, 8'hF9));
    q.push_back(mk(4'b0010, 0, 1, 2'd1, 1, 0, 0, 0, 0, 8'hF9));
    q.push_back(mk(4'b0000, 0, 0, 2'd1, 1, 0, 0, 0, 1, 8'hF9));
    q.push_back(mk(4'b0100, 1, 0, 2'd1, 1, 0, 0, 0, 0, 8'hF9));
    q.push_back(mk(4'b0100, 0, 1, 2'd2, 1, 0, 0, 0, 0, 8'hF9));
    q.push_back(mk(4'b0100, 1, 1, 2'd2, 1, 0, 0, 0, 0, 8'hF9));
    foreach (q[i]) begin
      drive(q[i].ring, q[i].clr);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL fault[%0d]: got %h expected %h", i, obs, q[i].exp);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t q[$];
    drive(4'b1000, 1'b0);
    vectors++;
    if (obs !== {1'b1, 2'd3, 1'b1, 1'b1, 3'b0, 8'hF9}) begin
      miscompares++;
      $display("FAIL pre_reset_step: got %h expected %h", obs, {1'b1, 2'd3, 1'b1, 1'b1, 3'b0, 8'hF9});
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", obs, 16'h0000);
    end
    ring_in = 4'b0011;
    @(negedge clock);
    reset = 1'b0;
    q.push_back(mk(4'b0011, 0, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0));
    q.push_back(mk(4'b0011, 1, 0, 2'd0, 0, 0, 0, 0, 1, 8'd0));
    q.push_back(mk(4'b0001, 1, 0, 2'd0, 0, 0, 0, 0, 0, 8'd0));
    q.push_back(mk(4'b0001, 0, 1, 2'd0, 0, 0, 0, 0, 0, 8'd0));
    foreach (q[i]) begin
      drive(q[i].ring, q[i].clr);
      vectors++;
      if (obs !== q[i].exp) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, obs, q[i].exp);
      end
    end
  endtask

`ifdef RING_MON_ERRCNT_EN
  task automatic test_err_cnt();
    logic [7:0] exp_cnt;
    reset = 1'b1;
    drive(4'b0001, 1'b0);
    reset = 1'b0;
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL err_cnt_reset: got %0d expected %0d", err_cnt, 0);
    end
    for (int n = 1; n <= 300; n++) begin
      drive(4'b1111, 1'b0);
      exp_cnt = (n > 255) ? 8'd255 : 8'(n);
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
        vectors++;
        if (err_cnt !== exp_cnt) begin
          miscompares++;
          $display("FAIL err_cnt[%0d]: got %0d expected %0d", n, err_cnt, exp_cnt);
        end
      end
    end
    drive(4'b1111, 1'b1);
    vectors++;
    if (err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL err_cnt_clr_inv: got %0d expected %0d", err_cnt, 1);
    end
    drive(4'b0001, 1'b1);
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL err_cnt_clr: got %0d expected %0d", err_cnt, 0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_jump();
    test_fault();
    test_async_reset();
`ifdef RING_MON_ERRCNT_EN
    test_err_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
